// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NUM_REQ requesters.
// Latches the winner's command, strobes the master once, and returns the result to the winner.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*16-1:0]           req_addr,
  input  logic [NUM_REQ*DATA_WIDTH*8-1:0] req_data,
  input  logic [NUM_REQ*8-1:0]            req_len,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [3:0]                      rsp_error,
  output logic [7:0]                      rsp_data,
  output logic                            m_valid_cmd,
  output logic [15:0]                     m_addr,
  output logic [DATA_WIDTH*8-1:0]         m_data_in,
  output logic [7:0]                      m_data_lenght,
  input  logic                            m_done,
  input  logic [3:0]                      m_error,
  input  logic [7:0]                      m_data_out,
  output logic [1:0]                      dbg_state
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int DW8 = DATA_WIDTH * 8;
  localparam int CW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Handshake: a requester holds req_valid with stable addr/data/len until it sees the
  // one-cycle req_ready pulse; the result arrives later as a one-cycle rsp_valid pulse
  // with rsp_error/rsp_data, which then hold until the next response.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       last_grant, grant, win_idx;
  logic [NUM_REQ-1:0]  upper_req;
  logic                reject;
  logic [CW-1:0]       tmo_cnt;
  logic                tmo_hit;
  logic [3:0]          res_err;
  logic [7:0]          res_data;
  logic [15:0]         sel_addr;
  logic [DW8-1:0]      sel_data;
  logic [7:0]          sel_len;
  logic                sel_read;
  logic                sel_reject;

  function automatic logic [GW-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    lowest_set = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = GW'(i);
    end
  endfunction

  // Requests above the last grant take precedence; otherwise wrap to the lowest index.
  always_comb begin
    upper_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_req[i] = req_valid[i] && (GW'(i) > last_grant);
    end
    win_idx = (|upper_req) ? lowest_set(upper_req) : lowest_set(req_valid);
  end

  assign sel_addr   = req_addr[win_idx*16 +: 16];
  assign sel_data   = req_data[win_idx*DW8 +: DW8];
  assign sel_len    = req_len[win_idx*8 +: 8];
  assign sel_read   = sel_addr[8];
  assign sel_reject = !sel_read && ((sel_len == 8'd0) || (32'(sel_len) > DATA_WIDTH));
  assign tmo_hit    = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  assign rsp_error = res_err;
  assign rsp_data  = res_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = reject ? RESP : WAIT;
      WAIT:    if (m_done || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    m_valid_cmd = 1'b0;
    dbg_state   = state;
    case (state)
      ISSUE: begin
        req_ready[grant] = 1'b1;
        m_valid_cmd      = !reject;
      end
      RESP:    rsp_valid[grant] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant    <= GW'(NUM_REQ - 1);
      grant         <= '0;
      reject        <= 1'b0;
      tmo_cnt       <= '0;
      res_err       <= '0;
      res_data      <= '0;
      m_addr        <= '0;
      m_data_in     <= '0;
      m_data_lenght <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant         <= win_idx;
            reject        <= sel_reject;
            m_addr        <= sel_addr;
            m_data_in     <= sel_data;
            m_data_lenght <= sel_read ? 8'd1 : sel_len;
          end
        end
        ISSUE: begin
          if (reject) begin
            res_err  <= 4'hE;
            res_data <= 8'h00;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + CW'(1);
          if (m_done) begin
            res_err  <= m_error;
            res_data <= m_data_out;
          end else if (tmo_hit) begin
            res_err  <= 4'hF;
            res_data <= 8'h00;
          end
        end
        RESP: begin
          last_grant <= grant;
          tmo_cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed latencies, grant order and result codes.
module tb_i2c_cmd_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*16-1:0]  req_addr = '0;
  logic [NR*64-1:0]  req_data = '0;
  logic [NR*8-1:0]   req_len = '0;
  logic [NR-1:0]     rsp_valid;
  logic [3:0]        rsp_error;
  logic [7:0]        rsp_data;
  logic              m_valid_cmd;
  logic [15:0]       m_addr;
  logic [63:0]       m_data_in;
  logic [7:0]        m_data_lenght;
  logic              m_done = 1'b0;
  logic [3:0]        m_error = '0;
  logic [7:0]        m_data_out = '0;
  logic [1:0]        dbg_state;

  i2c_cmd_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
    .m_valid_cmd(m_valid_cmd), .m_addr(m_addr), .m_data_in(m_data_in),
    .m_data_lenght(m_data_lenght), .m_done(m_done), .m_error(m_error),
    .m_data_out(m_data_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- model state (owned by the compare process) ----------------
  logic [NR-1:0]    p_valid = '0;
  logic [NR*16-1:0] p_addr = '0;
  logic [NR*64-1:0] p_data = '0;
  logic [NR*8-1:0]  p_len = '0;
  bit               p_done = 1'b0;
  logic [3:0]       p_err = '0;
  logic [7:0]       p_dout = '0;
  bit               s_idle = 1'b1;
  bit               s_resp = 1'b0;
  bit               busy = 1'b0;
  bit               rej = 1'b0;
  int               win = 0;
  int               last = NR - 1;
  int               g_cyc = 0;
  logic [15:0]      e_addr = '0;
  logic [63:0]      e_data = '0;
  logic [7:0]       e_len = '0;
  logic [3:0]       e_err = '0;
  logic [7:0]       e_rdata = '0;
  bit               rdata_known = 1'b1;

  int grant_q[$];
  int cmd_count = 0;
  int rsp_count = 0;

  function automatic int rr_pick(input logic [NR-1:0] m, input int l);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (l + k) % NR;
      if (m[c]) return c;
    end
    return 0;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit eg, er, nidle;
    logic [NR-1:0] e_ready, e_rspv;
    bit e_cmd;
    logic [7:0] ln;
    if (!rst) begin
      vectors++;
      if (req_ready != 0 || rsp_valid != 0 || m_valid_cmd || m_addr != 0 || m_data_in != 0 ||
          m_data_lenght != 0 || rsp_error != 0 || rsp_data != 0) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d: ready=%b rspv=%b cmd=%b addr=%h len=%0d err=%h data=%h, all must be 0",
                 cyc, req_ready, rsp_valid, m_valid_cmd, m_addr, m_data_lenght, rsp_error, rsp_data);
      end
      s_idle = 1'b1; s_resp = 1'b0; busy = 1'b0; last = NR - 1;
      e_addr = '0; e_data = '0; e_len = '0; e_err = '0; e_rdata = '0; rdata_known = 1'b1;
      p_valid = '0; p_done = 1'b0;
    end else begin
      eg = s_idle && (p_valid != 0);
      er = 1'b0;
      if (eg) begin
        win    = rr_pick(p_valid, last);
        g_cyc  = cyc;
        busy   = 1'b1;
        e_addr = p_addr[win*16 +: 16];
        e_data = p_data[win*64 +: 64];
        ln     = p_len[win*8 +: 8];
        rej    = !e_addr[8] && (ln == 0 || ln > DW);
        e_len  = e_addr[8] ? 8'd1 : ln;
      end else if (busy) begin
        if (rej) er = (cyc == g_cyc + 1);
        else     er = (p_done && cyc >= g_cyc + 2) || (cyc == g_cyc + TO + 1);
        if (er) begin
          if (rej) begin
            e_err = 4'hE; rdata_known = 1'b0;
          end else if (p_done) begin
            e_err = p_err; e_rdata = p_dout; rdata_known = 1'b1;
          end else begin
            e_err = 4'hF; e_rdata = 8'h00; rdata_known = 1'b1;
          end
          last = win;
          busy = 1'b0;
        end
      end
      e_ready = '0;
      if (eg) e_ready[win] = 1'b1;
      e_cmd = eg && !rej;
      e_rspv = '0;
      if (er) e_rspv[win] = 1'b1;
      vectors++;
      if (req_ready !== e_ready || m_valid_cmd !== e_cmd || rsp_valid !== e_rspv ||
          m_addr !== e_addr || m_data_in !== e_data || m_data_lenght !== e_len ||
          rsp_error !== e_err || (rdata_known && rsp_data !== e_rdata)) begin
        miscompares++;
        $display("FAIL cycle_check cyc=%0d: got ready=%b cmd=%b rspv=%b addr=%h din=%h len=%0d err=%h data=%h, want ready=%b cmd=%b rspv=%b addr=%h din=%h len=%0d err=%h data=%h",
                 cyc, req_ready, m_valid_cmd, rsp_valid, m_addr, m_data_in, m_data_lenght, rsp_error, rsp_data,
                 e_ready, e_cmd, e_rspv, e_addr, e_data, e_len, e_err, e_rdata);
      end
      if (req_ready != 0) grant_q.push_back(idx_of(req_ready));
      if (m_valid_cmd) cmd_count++;
      if (rsp_valid != 0) rsp_count++;
      nidle  = s_resp || (s_idle && !eg);
      s_idle = nidle;
      s_resp = er;
      p_valid = req_valid; p_addr = req_addr; p_data = req_data; p_len = req_len;
      p_done = m_done; p_err = m_error; p_dout = m_data_out;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [63:0] d, input logic [7:0] l);
    req_addr[i*16 +: 16] = a;
    req_data[i*64 +: 64] = d;
    req_len[i*8 +: 8]    = l;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_grant(input int lim, output int g);
    g = -1;
    for (int i = 0; i < lim && g < 0; i++) begin
      if (req_ready != 0) g = cyc;
      else tick();
    end
    vectors++;
    if (g < 0) begin
      miscompares++;
      $display("FAIL wait_grant: no req_ready within %0d cycles", lim);
    end
  endtask

  task automatic wait_rsp(input int lim, output int r);
    r = -1;
    for (int i = 0; i < lim && r < 0; i++) begin
      if (rsp_valid != 0) r = cyc;
      else tick();
    end
    vectors++;
    if (r < 0) begin
      miscompares++;
      $display("FAIL wait_rsp: no rsp_valid within %0d cycles", lim);
    end
  endtask

  task automatic serve(input int d, input logic [3:0] e, input logic [7:0] dd);
    repeat (d) tick();
    m_done = 1'b1; m_error = e; m_data_out = dd;
    tick();
    m_done = 1'b0; m_error = '0; m_data_out = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int g, g2, r, t0, c0, rc0, gq0;
    int fair_exp[5];
    fair_exp = '{0, 1, 2, 3, 0};

    repeat (3) tick();
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_m_addr", int'(m_addr), 0);
    chk("reset_m_valid_cmd", int'(m_valid_cmd), 0);
    rst = 1'b1;
    tick();

    // single write from requester 0
    c0 = cmd_count;
    set_req(0, 16'hAABB, 64'h0000_0000_0000_1122, 8'd2);
    t0 = cyc;
    wait_grant(5, g);
    chk("single_grant_latency", g - t0, 1);
    chk("single_req_ready", int'(req_ready), 1);
    chk("single_m_valid_cmd", int'(m_valid_cmd), 1);
    chk("single_m_data_lenght", int'(m_data_lenght), 2);
    chk("single_m_addr", int'(m_addr), 16'hAABB);
    req_valid[0] = 1'b0;
    serve(12, 4'h0, 8'h00);
    wait_rsp(20, r);
    chk("single_rsp_latency", r - g, 13);
    chk("single_rsp_valid", int'(rsp_valid), 1);
    chk("single_rsp_error", int'(rsp_error), 0);
    chk("single_cmd_pulses", cmd_count - c0, 1);

    // fairness: all four hold req_valid continuously
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, 16'h2000 + 16'(i), 64'(i + 1), 8'(i + 1));
    gq0 = grant_q.size();
    for (int k = 0; k < 5; k++) begin
      wait_grant(30, g);
      if (k == 4) req_valid = '0;
      serve(2, 4'h0, 8'h00);
      wait_rsp(10, r);
    end
    tick();
    chk("fair_grant_count", grant_q.size() - gq0, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("fair_order_%0d", k), grant_q[gq0 + k], fair_exp[k]);

    // read path from requester 2
    set_req(2, 16'h51C0, 64'h0, 8'd5);
    wait_grant(5, g);
    chk("read_req_ready", int'(req_ready), 4'b0100);
    chk("read_m_data_lenght", int'(m_data_lenght), 1);
    req_valid[2] = 1'b0;
    serve(4, 4'h0, 8'h3C);
    wait_rsp(10, r);
    chk("read_rsp_valid", int'(rsp_valid), 4'b0100);
    chk("read_rsp_data", int'(rsp_data), 8'h3C);
    chk("read_rsp_error", int'(rsp_error), 0);

    // rejected writes: len 0 then len 9
    c0 = cmd_count;
    set_req(1, 16'h4410, 64'h0, 8'd0);
    wait_grant(5, g);
    chk("rej0_m_valid_cmd", int'(m_valid_cmd), 0);
    req_valid[1] = 1'b0;
    wait_rsp(5, r);
    chk("rej0_rsp_latency", r - g, 1);
    chk("rej0_rsp_error", int'(rsp_error), 4'hE);
    chk("rej0_rsp_valid", int'(rsp_valid), 4'b0010);
    tick();
    set_req(1, 16'h4410, 64'h0, 8'd9);
    wait_grant(5, g);
    req_valid[1] = 1'b0;
    wait_rsp(5, r);
    chk("rej9_rsp_latency", r - g, 1);
    chk("rej9_rsp_error", int'(rsp_error), 4'hE);
    chk("rej_cmd_pulses", cmd_count - c0, 0);

    // len == DATA_WIDTH is accepted
    set_req(3, 16'h4412, 64'hDEAD_BEEF_0102_0304, 8'd8);
    wait_grant(5, g);
    chk("len8_m_valid_cmd", int'(m_valid_cmd), 1);
    chk("len8_m_data_lenght", int'(m_data_lenght), 8);
    req_valid[3] = 1'b0;
    serve(3, 4'h0, 8'h00);
    wait_rsp(10, r);
    chk("len8_rsp_error", int'(rsp_error), 0);

    // timeout on requester 1 while 0 and 3 wait
    set_req(1, 16'h6620, 64'h55, 8'd1);
    wait_grant(5, g);
    chk("tmo_req_ready", int'(req_ready), 4'b0010);
    req_valid[1] = 1'b0;
    set_req(0, 16'h6600, 64'h10, 8'd1);
    set_req(3, 16'h6630, 64'h30, 8'd1);
    wait_rsp(40, r);
    chk("tmo_rsp_latency", r - g, TO + 1);
    chk("tmo_rsp_error", int'(rsp_error), 4'hF);
    chk("tmo_rsp_data", int'(rsp_data), 0);
    chk("tmo_rsp_valid", int'(rsp_valid), 4'b0010);
    wait_grant(5, g2);
    chk("tmo_next_latency", g2 - r, 2);
    chk("tmo_next_grant", int'(req_ready), 4'b1000);
    req_valid[3] = 1'b0;
    serve(16, 4'h5, 8'hA5);
    wait_rsp(5, r);
    chk("done_last_cycle_latency", r - g2, 17);
    chk("done_last_cycle_error", int'(rsp_error), 4'h5);
    chk("done_last_cycle_data", int'(rsp_data), 8'hA5);
    wait_grant(5, g);
    chk("after_tmo_grant0", int'(req_ready), 4'b0001);
    req_valid[0] = 1'b0;
    serve(1, 4'h0, 8'h11);
    wait_rsp(5, r);
    chk("min_wait_latency", r - g, 2);
    chk("min_wait_data", int'(rsp_data), 8'h11);

    // reset in WAIT, then a stray m_done while idle
    set_req(2, 16'h7720, 64'h77, 8'd1);
    wait_grant(5, g);
    chk("rst_pre_grant", int'(req_ready), 4'b0100);
    req_valid[2] = 1'b0;
    repeat (3) tick();
    rc0 = rsp_count;
    rst = 1'b0;
    #1;
    chk("rst_async_m_addr", int'(m_addr), 0);
    chk("rst_async_rsp_error", int'(rsp_error), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    m_done = 1'b1; m_error = 4'h3; m_data_out = 8'h77;
    tick();
    m_done = 1'b0; m_error = '0; m_data_out = '0;
    repeat (3) tick();
    chk("rst_no_rsp", rsp_count - rc0, 0);
    chk("stray_done_rsp_error", int'(rsp_error), 0);
    set_req(0, 16'h8800, 64'h1, 8'd1);
    set_req(1, 16'h8810, 64'h2, 8'd1);
    set_req(2, 16'h8820, 64'h3, 8'd1);
    wait_grant(5, g);
    chk("rst_next_grant", int'(req_ready), 4'b0001);
    req_valid = '0;
    serve(2, 4'h0, 8'h00);
    wait_rsp(5, r);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
